// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester: FSM encoding and default widths.
package gcd_pkg;

    localparam int W_DEF     = 16;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_client_if.sv
// Control/data handshake between the requester (master) and the GCD unit (slave).
interface gcd_client_if
    import gcd_pkg::*;
#(
    parameter int W = W_DEF
);

    logic         gcd_input_available;
    logic [W-1:0] gcd_operand_a;
    logic [W-1:0] gcd_operand_b;
    logic         gcd_result_rdy;
    logic [W-1:0] gcd_result;
    logic         gcd_result_taken;

    modport master (
        output gcd_input_available, gcd_operand_a, gcd_operand_b, gcd_result_taken,
        input  gcd_result_rdy, gcd_result
    );

    modport slave (
        input  gcd_input_available, gcd_operand_a, gcd_operand_b, gcd_result_taken,
        output gcd_result_rdy, gcd_result
    );

endinterface

// File: rtl/gcd_operand_fifo.sv
// Operand-pair FIFO: DEPTH entries of {A,B}, first-word-fall-through read port.
module gcd_operand_fifo
    import gcd_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic [2*W-1:0] wdata,
    output logic [2*W-1:0] rdata,
    output logic           full,
    output logic           empty
);

    localparam int AW = $clog2(DEPTH);

    logic [2*W-1:0] mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/gcd_client.sv
// Requester for the GCD unit: queues host operand pairs, issues them one at a time,
// and returns each result with its issue-to-take latency on a valid/ready port.
module gcd_client
    import gcd_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_gcd,
    output logic [CNT_W-1:0] rsp_cycles,
    gcd_client_if.master     gcd,
    output logic [CNT_W-1:0] done_count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    state_t           state_q, state_d;
    logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [W-1:0]     rsp_gcd_q, rsp_gcd_d;
    logic [CNT_W-1:0] lat_q, lat_d, rsp_cycles_q, rsp_cycles_d, done_q, done_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [2*W-1:0]   fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_pop, take;

    gcd_operand_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid),
        .pop   (fifo_pop),
        .wdata ({req_a, req_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        lat_d        = lat_q;
        rsp_gcd_d    = rsp_gcd_q;
        rsp_cycles_d = rsp_cycles_q;
        done_d       = done_q;
        rsp_valid_d  = rsp_valid_q && !rsp_ready;
        fifo_pop     = 1'b0;
        take         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop         = 1'b1;
                    {op_a_d, op_b_d} = fifo_rdata;
                    lat_d            = '0;
                    state_d          = ISSUE;
                end
            end
            // The ISSUE edge counts toward latency, hence the increment here too.
            ISSUE: begin
                lat_d   = sat_inc(lat_q);
                state_d = BUSY;
            end
            BUSY: begin
                lat_d = sat_inc(lat_q);
                if (gcd.gcd_result_rdy && (!rsp_valid_q || rsp_ready)) begin
                    take         = 1'b1;
                    rsp_gcd_d    = gcd.gcd_result;
                    rsp_cycles_d = sat_inc(lat_q);
                    rsp_valid_d  = 1'b1;
                    done_d       = done_q + ONE;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            lat_q        <= '0;
            rsp_gcd_q    <= '0;
            rsp_cycles_q <= '0;
            done_q       <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            lat_q        <= lat_d;
            rsp_gcd_q    <= rsp_gcd_d;
            rsp_cycles_q <= rsp_cycles_d;
            done_q       <= done_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign req_ready               = !fifo_full;
    assign rsp_valid               = rsp_valid_q;
    assign rsp_gcd                 = rsp_gcd_q;
    assign rsp_cycles              = rsp_cycles_q;
    assign done_count              = done_q;
    assign busy                    = (state_q != IDLE);
    assign gcd.gcd_input_available = (state_q == ISSUE);
    assign gcd.gcd_operand_a       = op_a_q;
    assign gcd.gcd_operand_b       = op_b_q;
    assign gcd.gcd_result_taken    = take;

endmodule

// File: tb/tb_gcd_client.sv
// Directed bench for gcd_client against a behavioural subtract-and-swap GCD unit.
module tb_gcd_client;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_gcd;
    logic [7:0]  rsp_cycles;
    logic [7:0]  done_count;
    logic        busy;

    gcd_client_if #(.W(16)) gif ();

    gcd_client #(.W(16), .DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_gcd    (rsp_gcd),
        .rsp_cycles (rsp_cycles),
        .gcd        (gif),
        .done_count (done_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // GCD unit model: WAIT(0) -> CALC(1) -> DONE(2), optional stall before computing.
    int          m_state = 0;
    int          m_stall = 0;
    int          stall_cfg = 0;
    logic [15:0] m_a = '0, m_b = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 0;
            m_stall <= 0;
            m_a     <= '0;
            m_b     <= '0;
        end else begin
            case (m_state)
                0: if (gif.gcd_input_available) begin
                    m_a     <= gif.gcd_operand_a;
                    m_b     <= gif.gcd_operand_b;
                    m_stall <= stall_cfg;
                    m_state <= 1;
                end
                1: begin
                    if (m_stall > 0) m_stall <= m_stall - 1;
                    else if (m_a < m_b) begin m_a <= m_b; m_b <= m_a; end
                    else if (m_b != 0) m_a <= m_a - m_b;
                    else m_state <= 2;
                end
                default: if (gif.gcd_result_taken) m_state <= 0;
            endcase
        end
    end

    assign gif.gcd_result_rdy = (m_state == 2);
    assign gif.gcd_result     = m_a;

    // Observation: cycle index, issue/take timing, consumed responses.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int issue_cyc = 0, push_cyc = 0, ia_cycles = 0, full_seen = 0;
    int lat_q[$];
    int gcd_q[$];
    int cyc_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (gif.gcd_input_available) begin
                issue_cyc <= cyc;
                ia_cycles <= ia_cycles + 1;
            end
            if (gif.gcd_result_taken) lat_q.push_back(cyc - issue_cyc + 1);
            if (rsp_valid && rsp_ready) begin
                gcd_q.push_back(int'(rsp_gcd));
                cyc_q.push_back(int'(rsp_cycles));
            end
            if (req_valid && req_ready) push_cyc <= cyc;
            if (!req_ready) full_seen <= full_seen + 1;
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        stall_cfg = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push_op(input logic [15:0] a, input logic [15:0] b);
        int n;
        logic done;
        n = 0; done = 1'b0;
        req_a = a; req_b = b; req_valid = 1'b1;
        while (!done && n < 3000) begin
            @(negedge clk);
            done = req_ready;
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL push_timeout got=req_ready_low required=accept");
        end
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n;
        n = 0;
        while (gcd_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        if (gcd_q.size() < target) begin
            checks++; failures++;
            $display("FAIL rsp_timeout got=%0d required=%0d responses", gcd_q.size(), target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b required=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b required=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b required=0", busy); end
        checks++; if (gif.gcd_input_available !== 1'b0) begin failures++; $display("FAIL reset_ia got=%0b required=0", gif.gcd_input_available); end
        checks++; if (gif.gcd_result_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%0b required=0", gif.gcd_result_taken); end
        checks++; if (done_count !== 8'd0 || rsp_cycles !== 8'd0 || rsp_gcd !== 16'd0) begin
            failures++; $display("FAIL reset_regs got=%0d/%0d/%0d required=0/0/0", done_count, rsp_cycles, rsp_gcd);
        end
        checks++; if (gif.gcd_operand_a !== 16'd0 || gif.gcd_operand_b !== 16'd0) begin
            failures++; $display("FAIL reset_operands got=%0d/%0d required=0/0", gif.gcd_operand_a, gif.gcd_operand_b);
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_single_op();
        int b, lb, ia0;
        do_reset();
        rsp_ready = 1'b1;
        b = gcd_q.size(); lb = lat_q.size(); ia0 = ia_cycles;
        push_op(16'd48, 16'd18);
        wait_rsp(b + 1, 200);
        repeat (3) @(posedge clk); #1;
        checks++; if (ia_cycles - ia0 != 1) begin failures++; $display("FAIL single_ia_width got=%0d required=1 cycles", ia_cycles - ia0); end
        checks++; if (issue_cyc - push_cyc != 2) begin failures++; $display("FAIL single_issue_delay got=%0d required=2", issue_cyc - push_cyc); end
        checks++; if (gcd_q[b] != 6) begin failures++; $display("FAIL single_gcd got=%0d required=6", gcd_q[b]); end
        checks++; if (cyc_q[b] != 11) begin failures++; $display("FAIL single_cycles got=%0d required=11", cyc_q[b]); end
        checks++; if (cyc_q[b] != lat_q[lb]) begin failures++; $display("FAIL single_cycles_meas got=%0d required=%0d", cyc_q[b], lat_q[lb]); end
        checks++; if (done_count !== 8'd1) begin failures++; $display("FAIL single_done got=%0d required=1", done_count); end
    endtask

    task automatic test_fifo_order();
        int b, lb, f0;
        int exp_g[5];
        logic [15:0] va[5];
        logic [15:0] vb[5];
        exp_g = '{4, 7, 1, 9, 9};
        va    = '{16'd12, 16'd35, 16'd17, 16'd0, 16'd9};
        vb    = '{16'd8, 16'd14, 16'd5, 16'd9, 16'd0};
        do_reset();
        rsp_ready = 1'b1;
        b = gcd_q.size(); lb = lat_q.size(); f0 = full_seen;
        for (int i = 0; i < 5; i++) push_op(va[i], vb[i]);
        wait_rsp(b + 5, 600);
        checks++; if (full_seen == f0) begin failures++; $display("FAIL fifo_full_seen got=never required=req_ready_low"); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (gcd_q[b+i] != exp_g[i]) begin failures++; $display("FAIL fifo_order_%0d got=%0d required=%0d", i, gcd_q[b+i], exp_g[i]); end
            checks++; if (cyc_q[b+i] != lat_q[lb+i]) begin failures++; $display("FAIL fifo_cycles_%0d got=%0d required=%0d", i, cyc_q[b+i], lat_q[lb+i]); end
        end
        checks++; if (done_count !== 8'd5) begin failures++; $display("FAIL fifo_done got=%0d required=5", done_count); end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        push_op(16'd10, 16'd4);
        push_op(16'd21, 16'd6);
        n = 0;
        while (!(rsp_valid && busy && gif.gcd_result_rdy) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin checks++; failures++; $display("FAIL bp_wait_timeout got=no_stall required=stall"); end
        repeat (3) @(negedge clk);
        checks++; if (gif.gcd_result_taken !== 1'b0) begin failures++; $display("FAIL bp_taken_hold got=%0b required=0", gif.gcd_result_taken); end
        checks++; if (busy !== 1'b1 || gif.gcd_result_rdy !== 1'b1) begin failures++; $display("FAIL bp_busy_hold got=%0b/%0b required=1/1", busy, gif.gcd_result_rdy); end
        checks++; if (rsp_valid !== 1'b1 || rsp_gcd !== 16'd2) begin failures++; $display("FAIL bp_first_held got=%0b/%0d required=1/2", rsp_valid, rsp_gcd); end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (gif.gcd_result_taken !== 1'b1) begin failures++; $display("FAIL bp_take_same_cycle got=%0b required=1", gif.gcd_result_taken); end
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_gcd !== 16'd3) begin failures++; $display("FAIL bp_second got=%0b/%0d required=1/3", rsp_valid, rsp_gcd); end
        checks++; if (done_count !== 8'd2 || busy !== 1'b0) begin failures++; $display("FAIL bp_done got=%0d/%0b required=2/0", done_count, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int b, ia0;
        do_reset();
        rsp_ready = 1'b1;
        push_op(16'd48, 16'd18);
        push_op(16'd12, 16'd8);
        push_op(16'd35, 16'd14);
        checks++; if (busy !== 1'b1 || gif.gcd_input_available !== 1'b0) begin failures++; $display("FAIL mid_in_busy got=%0b/%0b required=1/0", busy, gif.gcd_input_available); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL mid_reset_ctrl got=%0b/%0b/%0b required=0/1/0", busy, req_ready, rsp_valid);
        end
        checks++; if (done_count !== 8'd0 || gif.gcd_operand_a !== 16'd0 || gif.gcd_result_taken !== 1'b0) begin
            failures++; $display("FAIL mid_reset_regs got=%0d/%0d/%0b required=0/0/0", done_count, gif.gcd_operand_a, gif.gcd_result_taken);
        end
        @(posedge clk); #1 reset = 1'b0;
        ia0 = ia_cycles;
        repeat (6) @(posedge clk); #1;
        checks++; if (ia_cycles != ia0 || busy !== 1'b0) begin failures++; $display("FAIL mid_fifo_empty got=%0d_issues required=0", ia_cycles - ia0); end
        b = gcd_q.size();
        push_op(16'd21, 16'd6);
        wait_rsp(b + 1, 200);
        checks++; if (gcd_q[b] != 3) begin failures++; $display("FAIL mid_after_gcd got=%0d required=3", gcd_q[b]); end
        checks++; if (done_count !== 8'd1) begin failures++; $display("FAIL mid_after_done got=%0d required=1", done_count); end
    endtask

    task automatic test_saturation();
        int b;
        do_reset();
        stall_cfg = 300;
        rsp_ready = 1'b1;
        b = gcd_q.size();
        push_op(16'd48, 16'd18);
        wait_rsp(b + 1, 600);
        checks++; if (cyc_q[b] != 255) begin failures++; $display("FAIL sat_cycles got=%0d required=255", cyc_q[b]); end
        checks++; if (gcd_q[b] != 6) begin failures++; $display("FAIL sat_gcd got=%0d required=6", gcd_q[b]); end
        stall_cfg = 0;
    endtask

    task automatic test_wrap();
        int b;
        do_reset();
        rsp_ready = 1'b1;
        b = gcd_q.size();
        for (int i = 0; i < 256; i++) push_op(16'd1, 16'd1);
        wait_rsp(b + 256, 5000);
        for (int i = 0; i < 256; i++) begin
            checks++; if (gcd_q[b+i] != 1) begin failures++; $display("FAIL wrap_gcd_%0d got=%0d required=1", i, gcd_q[b+i]); end
        end
        checks++; if (done_count !== 8'd0) begin failures++; $display("FAIL wrap_done got=%0d required=0", done_count); end
        checks++; if (gcd_q.size() - b != 256) begin failures++; $display("FAIL wrap_count got=%0d required=256", gcd_q.size() - b); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0;
        test_reset();
        test_single_op();
        test_fifo_order();
        test_backpressure();
        test_reset_mid_op();
        test_saturation();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
